// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : RV32I opcode constants, hazard FSM states, reg-use fns |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef enum logic [0:0] {
      HZ_RUN  = 1'b0,
      HZ_WAIT = 1'b1
   } hz_state_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl : stall/flush control for the 5-stage RV32I pipeline |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int MAX_WAIT  = 255,
   parameter int WAIT_W    = 8,
   parameter int STORE_FWD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      Instruction_IFID,
   input  logic [31:0]      Instruction_IDEX,
   input  logic             memRead_IDEX,
   input  logic             memRead_EXMEM,
   input  logic             memWrite_EXMEM,
   input  logic             dmem_ready,
   input  logic             branch_taken_EX,
   output logic             stall_PC,
   output logic             stall_IFID,
   output logic             stall_IDEX,
   output logic             stall_EXMEM,
   output logic             stall_MEMWB,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic             flush_EXMEM,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             mem_timeout,
   output logic             mem_wait
);

   localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

   logic [4:0]  w_rd_idex;
   logic [4:0]  w_rs1_ifid;
   logic [4:0]  w_rs2_ifid;
   logic [6:0]  w_op_ifid;
   logic        w_is_store;
   logic        w_rs1_hit;
   logic        w_rs2_hit;
   logic        w_load_use;
   logic        w_mem_busy;
   logic        w_any_stall;
   logic        w_flush_evt;
   logic        w_unused_bits;

   hz_state_t          r_state;
   hz_state_t          w_state_nxt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [WAIT_W-1:0]  w_wait_cnt_nxt;
   logic               r_timeout;

   assign w_rd_idex  = Instruction_IDEX[11:7];
   assign w_rs1_ifid = Instruction_IFID[19:15];
   assign w_rs2_ifid = Instruction_IFID[24:20];
   assign w_op_ifid  = Instruction_IFID[6:0];
   assign w_is_store = (w_op_ifid == OP_S);

   assign w_unused_bits = ^{Instruction_IDEX[31:12], Instruction_IDEX[6:0],
                            Instruction_IFID[31:25], Instruction_IFID[11:7]};

   // Store data from a load is forwarded in MEM, so only the rs2 term may be waived.
   assign w_rs1_hit  = uses_rs1(w_op_ifid) && (w_rs1_ifid == w_rd_idex);
   assign w_rs2_hit  = uses_rs2(w_op_ifid) && (w_rs2_ifid == w_rd_idex) &&
                       !((STORE_FWD != 0) && w_is_store);
   assign w_load_use = memRead_IDEX && (w_rd_idex != 5'd0) && (w_rs1_hit || w_rs2_hit);

   assign w_mem_busy = (memRead_EXMEM || memWrite_EXMEM) && !dmem_ready;

   always_comb begin
      stall_PC    = 1'b0;
      stall_IFID  = 1'b0;
      stall_IDEX  = 1'b0;
      stall_EXMEM = 1'b0;
      stall_MEMWB = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEX  = 1'b0;
      flush_EXMEM = 1'b0;
      if (w_mem_busy) begin
         // MEM/WB freezes too so WB-to-MEM store-data forwarding stays valid.
         stall_PC    = 1'b1;
         stall_IFID  = 1'b1;
         stall_IDEX  = 1'b1;
         stall_EXMEM = 1'b1;
         stall_MEMWB = 1'b1;
      end else if (branch_taken_EX) begin
         flush_IFID  = 1'b1;
         flush_IDEX  = 1'b1;
      end else if (w_load_use) begin
         stall_PC    = 1'b1;
         stall_IFID  = 1'b1;
         flush_IDEX  = 1'b1;
      end
   end

   assign w_any_stall = stall_PC | stall_IFID | stall_IDEX | stall_EXMEM | stall_MEMWB;
   assign w_flush_evt = !w_mem_busy && branch_taken_EX;

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         HZ_RUN: begin
            if (w_mem_busy) begin
               w_state_nxt    = HZ_WAIT;
               w_wait_cnt_nxt = WAIT_W'(1);
            end
         end
         HZ_WAIT: begin
            if (!w_mem_busy) begin
               w_state_nxt    = HZ_RUN;
               w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            w_state_nxt    = HZ_RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= HZ_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_wait_cnt_nxt == c_MAX_WAIT) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign mem_wait    = (r_state == HZ_WAIT);
   assign mem_timeout = r_timeout;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_any_stall),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_flush_evt),
      .count (flush_events)
   );

endmodule
`default_nettype wire
